// File: rtl/uart_autobaud.sv
// Auto-baud detector: times a 0x55 8N1 sync character on rx and emits one UART config word.
// Optional AUTOBAUD_RELOCK_EN: re-arm after each handshake so every later sync sends a new word.
module uart_autobaud #(
  parameter int unsigned PARITY        = 0,
  parameter int unsigned BYTE_SIZE     = 8,
  parameter int unsigned STOP_BITS     = 0,
  parameter int unsigned MIN_PRESCALER = 4,
  parameter int unsigned MAX_PRESCALER = 65535,
  parameter int unsigned IDLE_MIN      = 32,
  parameter int unsigned TOL_SHIFT     = 3
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic        rx,
  output logic [23:0] m_axis_config_tdata,
  output logic        m_axis_config_tvalid,
  input  logic        m_axis_config_tready,
  output logic        locked,
  output logic        error
);

  localparam logic [2:0] S_IDLE_WAIT = 3'd0;
  localparam logic [2:0] S_ARMED     = 3'd1;
  localparam logic [2:0] S_MEASURE   = 3'd2;
  localparam logic [2:0] S_CHECK     = 3'd3;
  localparam logic [2:0] S_SEND      = 3'd4;
  localparam logic [2:0] S_LOCKED    = 3'd5;

  localparam int unsigned IDLE_W = (IDLE_MIN > 0) ? $clog2(IDLE_MIN + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MIN_C = IDLE_W'(IDLE_MIN);
  localparam logic [17:0] INTV_LIMIT = 18'(2 * MAX_PRESCALER + 1);
  localparam logic [19:0] MIN_P = 20'(MIN_PRESCALER);
  localparam logic [19:0] MAX_P = 20'(MAX_PRESCALER);
  localparam logic [7:0]  CFG_HI = {STOP_BITS[0], BYTE_SIZE[3:0], PARITY[2:0]};

  logic              r_rx_meta, r_rx_sync, r_rx_prev;
  logic [2:0]        r_state;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [17:0]       r_intv_cnt;
  logic [19:0]       r_total;
  logic [2:0]        r_edge_cnt;
  logic [17:0]       r_intv [4];
  logic [23:0]       r_tdata;
  logic              r_tvalid, r_locked, r_error;

  logic        w_fall;
  logic [17:0] w_tol;
  logic [19:0] w_presc;
  logic        w_intv_ok, w_check_ok;

  function automatic logic [17:0] abs_diff(input logic [17:0] a, input logic [17:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign w_fall    = r_rx_prev & ~r_rx_sync;
  assign w_tol     = r_intv[0] >> TOL_SHIFT;
  // Round to nearest: total spans 8 bit periods.
  assign w_presc   = (r_total + 20'd4) >> 3;
  assign w_intv_ok = (abs_diff(r_intv[1], r_intv[0]) <= w_tol) &&
                     (abs_diff(r_intv[2], r_intv[0]) <= w_tol) &&
                     (abs_diff(r_intv[3], r_intv[0]) <= w_tol);
  assign w_check_ok = w_intv_ok && (w_presc >= MIN_P) && (w_presc <= MAX_P);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_state    <= S_IDLE_WAIT;
      r_idle_cnt <= '0;
      r_intv_cnt <= '0;
      r_total    <= '0;
      r_edge_cnt <= '0;
      r_intv     <= '{default: '0};
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_locked   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_error   <= 1'b0;
      case (r_state)
        S_IDLE_WAIT: begin
          if (!r_rx_sync) r_idle_cnt <= '0;
          else if (r_idle_cnt < IDLE_MIN_C) r_idle_cnt <= r_idle_cnt + 1'b1;
          if (enable && r_rx_sync && (r_idle_cnt >= IDLE_MIN_C)) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (!enable) begin
            r_state    <= S_IDLE_WAIT;
            r_idle_cnt <= '0;
          end else if (w_fall) begin
            r_intv_cnt <= '0;
            r_total    <= '0;
            r_edge_cnt <= 3'd1;
            r_state    <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (!enable || (r_intv_cnt > INTV_LIMIT)) begin
            r_error    <= 1'b1;
            r_state    <= S_IDLE_WAIT;
            r_idle_cnt <= '0;
          end else begin
            r_total <= r_total + 1'b1;
            if (w_fall) begin
              // Store the full interval including this edge cycle.
              r_intv[2'(r_edge_cnt - 3'd1)] <= r_intv_cnt + 1'b1;
              r_intv_cnt <= '0;
              r_edge_cnt <= r_edge_cnt + 1'b1;
              if (r_edge_cnt == 3'd4) r_state <= S_CHECK;
            end else begin
              r_intv_cnt <= r_intv_cnt + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (w_check_ok) begin
            r_tdata  <= {CFG_HI, w_presc[15:0]};
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end else begin
            r_error    <= 1'b1;
            r_state    <= S_IDLE_WAIT;
            r_idle_cnt <= '0;
          end
        end
        S_SEND: begin
          if (m_axis_config_tready) begin
            r_tvalid <= 1'b0;
            r_locked <= 1'b1;
`ifdef AUTOBAUD_RELOCK_EN
            r_state    <= S_IDLE_WAIT;
            r_idle_cnt <= '0;
`else
            r_state <= S_LOCKED;
`endif
          end
        end
        S_LOCKED: begin
          if (!enable) begin
            r_locked   <= 1'b0;
            r_state    <= S_IDLE_WAIT;
            r_idle_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE_WAIT;
      endcase
    end
  end

  assign m_axis_config_tdata  = r_tdata;
  assign m_axis_config_tvalid = r_tvalid;
  assign locked               = r_locked;
  assign error                = r_error;

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: drives sync characters on rx and checks every cycle against an
// event model derived from pin-level edge timing, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_uart_autobaud;

  localparam int MAX_P = 300;
  localparam int MIN_P = 4;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic        rx = 1'b1;
  logic        tready = 1'b1;
  logic [23:0] tdata;
  logic        tvalid, locked, error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs = 0, vcyc = 0, epulse = 0;

  typedef struct { int cyc; bit is_err; logic [23:0] word; } ev_t;
  ev_t evq[$];

  logic        exp_valid = 1'b0;
  logic [23:0] exp_tdata = '0;
  logic        exp_locked = 1'b0;
  logic        exp_error = 1'b0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  uart_autobaud #(.MAX_PRESCALER(MAX_P)) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .enable               (enable),
    .rx                   (rx),
    .m_axis_config_tdata  (tdata),
    .m_axis_config_tvalid (tvalid),
    .m_axis_config_tready (tready),
    .locked               (locked),
    .error                (error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic push_ev(input int c, input bit e, input logic [23:0] w);
    ev_t ev;
    ev.cyc = c; ev.is_err = e; ev.word = w;
    evq.push_back(ev);
  endtask

  // Outcome of a full sync from the cycles at which each falling edge first reaches the pin sampler.
  task automatic judge(input int f0, input int f1, input int f2, input int f3, input int f4);
    int iv[4];
    int tol, presc;
    bit ok;
    iv[0] = f1 - f0; iv[1] = f2 - f1; iv[2] = f3 - f2; iv[3] = f4 - f3;
    tol = iv[0] / 8;
    ok = 1'b1;
    for (int i = 1; i < 4; i++) begin
      int d;
      d = (iv[i] > iv[0]) ? iv[i] - iv[0] : iv[0] - iv[i];
      if (d > tol) ok = 1'b0;
    end
    presc = (f4 - f0 + 4) / 8;
    if (presc < MIN_P || presc > MAX_P) ok = 1'b0;
    push_ev(f4 + 3, !ok, {1'b0, 4'd8, 3'd0, 16'(presc)});
  endtask

  task automatic send_char(input logic [7:0] d, input int period, input int sbit, input int extra,
                           input bit exp_timeout, input bit drop_en);
    logic [9:0] bits;
    int falls[5];
    int nf;
    logic prev;
    bits = {1'b1, d, 1'b0};
    nf = 0;
    prev = 1'b1;
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      if (prev && !bits[b]) begin
        if (nf < 5) falls[nf] = cyc + 1;
        nf++;
        if (exp_timeout && nf == 1) push_ev(cyc + 1 + 4 + 2 * MAX_P + 1, 1'b1, '0);
        if (drop_en && nf == 2) begin
          enable = 1'b0;
          push_ev(cyc + 1, 1'b1, '0);
        end
        if (!exp_timeout && !drop_en && nf == 5) judge(falls[0], falls[1], falls[2], falls[3], falls[4]);
      end
      prev = bits[b];
      tick(period + ((b == sbit) ? extra : 0));
    end
  endtask

  task automatic reenable();
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(40);
  endtask

  task automatic monitor();
    forever begin
      @(negedge aclk);
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        if (evq[0].is_err) exp_error = 1'b1;
        else begin
          exp_valid = 1'b1;
          exp_tdata = evq[0].word;
        end
        void'(evq.pop_front());
      end
      chk("tvalid", {31'd0, tvalid}, {31'd0, exp_valid});
      chk("tdata", {8'd0, tdata}, {8'd0, exp_tdata});
      chk("locked", {31'd0, locked}, {31'd0, exp_locked});
      chk("error", {31'd0, error}, {31'd0, exp_error});
      if (tvalid) vcyc++;
      if (error) epulse++;
      if (tvalid && tready && !areset) hs++;
      exp_error = 1'b0;
      if (exp_valid && tready) begin
        exp_valid  = 1'b0;
        exp_locked = 1'b1;
      end
`ifndef AUTOBAUD_RELOCK_EN
      else if (exp_locked && !enable) exp_locked = 1'b0;
`endif
      if (areset) begin
        exp_valid  = 1'b0;
        exp_tdata  = '0;
        exp_locked = 1'b0;
        evq.delete();
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    tick(4);
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", {8'd0, tdata}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    areset = 1'b0;
    enable = 1'b1;
    tick(40);

    send_char(8'h55, 16, -1, 0, 1'b0, 1'b0);
    tick(20);
    chk("t1_tdata", {8'd0, tdata}, 32'h400010);
    chk("t1_locked", {31'd0, locked}, 32'd1);
    chk("t1_hs", hs, 1);
    chk("t1_vcyc", vcyc, 1);
    chk("t1_err", epulse, 0);
    reenable();

    tready = 1'b0;
    send_char(8'h55, 217, -1, 0, 1'b0, 1'b0);
    tick(10);
    chk("t2_tvalid", {31'd0, tvalid}, 32'd1);
    chk("t2_tdata", {8'd0, tdata}, 32'h4000D9);
    tready = 1'b1;
    tick(3);
    chk("t2_hs", hs, 2);
    chk("t2_locked", {31'd0, locked}, 32'd1);
    reenable();

    send_char(8'h00, 16, -1, 0, 1'b1, 1'b0);
    tick(700);
    chk("t3_err", epulse, 1);
    chk("t3_hs", hs, 2);

    send_char(8'h55, 16, 5, 8, 1'b0, 1'b0);
    tick(20);
    chk("t4_err", epulse, 2);
    chk("t4_tdata_kept", {8'd0, tdata}, 32'h4000D9);
    tick(40);
    send_char(8'h55, 16, -1, 0, 1'b0, 1'b0);
    tick(20);
    chk("t4_relock", {8'd0, tdata}, 32'h400010);
    chk("t4_hs", hs, 3);
    reenable();

    send_char(8'h55, 16, 5, 4, 1'b0, 1'b0);
    tick(20);
    chk("tol_edge", {8'd0, tdata}, 32'h400011);
    reenable();

    send_char(8'h55, 300, -1, 0, 1'b0, 1'b0);
    tick(20);
    chk("max_ok", {8'd0, tdata}, 32'h40012C);
    reenable();
    send_char(8'h55, 301, -1, 0, 1'b0, 1'b0);
    tick(40);
    chk("max_bad", epulse, 3);
    send_char(8'h55, 4, -1, 0, 1'b0, 1'b0);
    tick(20);
    chk("min_ok", {8'd0, tdata}, 32'h400004);
    reenable();
    send_char(8'h55, 3, -1, 0, 1'b0, 1'b0);
    tick(40);
    chk("min_bad", epulse, 4);
    chk("bound_hs", hs, 6);

    send_char(8'h55, 16, -1, 0, 1'b0, 1'b1);
    enable = 1'b1;
    tick(40);
    chk("en_abort", epulse, 5);

    tready = 1'b0;
    send_char(8'h55, 16, -1, 0, 1'b0, 1'b0);
    tick(5);
    chk("t7_pre", {31'd0, tvalid}, 32'd1);
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    chk("t7_tvalid", {31'd0, tvalid}, 32'd0);
    chk("t7_tdata", {8'd0, tdata}, 32'd0);
    chk("t7_locked", {31'd0, locked}, 32'd0);
    tready = 1'b1;
    tick(40);
    send_char(8'h55, 16, -1, 0, 1'b0, 1'b0);
    tick(20);
    chk("t7_lock", {8'd0, tdata}, 32'h400010);
    chk("t7_hs", hs, 7);

`ifdef AUTOBAUD_RELOCK_EN
    tick(40);
    send_char(8'h55, 32, -1, 0, 1'b0, 1'b0);
    tick(20);
    chk("relock_tdata", {8'd0, tdata}, 32'h400020);
    chk("relock_locked", {31'd0, locked}, 32'd1);
    chk("relock_hs", hs, 8);
`endif

    chk("events_drained", evq.size(), 0);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
